dragon_head_ctrl: RTL and testbench

- Upstream stage of the dragon body segment queue. Produces the 10-bit head word (orientation and position), the per-frame movement counter, and the one-cycle length-update pulses that the body block consumes.
- The head chases a target (player) position one grid step per move period, using a small IDLE/CHASE/STUN state machine.
- Tracks dragon length (0..7) so that grow and shrink pulses stay within the body's 7-segment range.

---
 rtl/dragon_pkg.sv | 18 +
 rtl/dragon_head_ctrl_if.sv | 21 ++
 rtl/dragon_step_logic.sv | 17 +
 rtl/dragon_head_ctrl.sv | 85 ++++++++
 tb/tb_dragon_head_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/dragon_pkg.sv
// dragon_pkg: shared constants and state type for the dragon head controller
package dragon_pkg;
  localparam int COORD_W = 4;
  localparam int POS_W = 2 * COORD_W;
  localparam int HEAD_W = POS_W + 2;
  localparam int CNT_W = 6;
  localparam int LEN_W = 3;
  localparam logic [1:0] ORI_UP = 2'b00;
  localparam logic [1:0] ORI_RIGHT = 2'b01;
  localparam logic [1:0] ORI_DOWN = 2'b10;
  localparam logic [1:0] ORI_LEFT = 2'b11;
  localparam logic [1:0] LU_MOVE = 2'b00;
  localparam logic [1:0] LU_HEAL = 2'b01;
  localparam logic [1:0] LU_HIT = 2'b10;
  localparam logic [1:0] LU_IDLE = 2'b11;
  localparam logic [LEN_W-1:0] MAX_LEN = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_CHASE, S_STUN} state_t;
endpackage

// File: rtl/dragon_head_ctrl_if.sv
// dragon_head_ctrl_if: frame/event inputs and head/length outputs of the head controller
interface dragon_head_ctrl_if import dragon_pkg::*;;
  logic vsync;
  logic enable;
  logic [POS_W-1:0] target_pos;
  logic hit_event;
  logic heal_event;
  logic [HEAD_W-1:0] dragon_head;
  logic [CNT_W-1:0] movement_counter;
  logic [1:0] length_update;
  logic [LEN_W-1:0] dragon_len;
  logic stunned;
  modport master (
    output vsync, enable, target_pos, hit_event, heal_event,
    input dragon_head, movement_counter, length_update, dragon_len, stunned
  );
  modport slave (
    input vsync, enable, target_pos, hit_event, heal_event,
    output dragon_head, movement_counter, length_update, dragon_len, stunned
  );
endinterface

// File: rtl/dragon_step_logic.sv
// dragon_step_logic: one grid step of the head toward the target, x before y
module dragon_step_logic import dragon_pkg::*; (
  input  logic [HEAD_W-1:0] head,
  input  logic [POS_W-1:0]  target,
  output logic [HEAD_W-1:0] next_head
);
  logic [COORD_W-1:0] x, y, tx, ty;
  assign x = head[COORD_W-1:0];
  assign y = head[POS_W-1:COORD_W];
  assign tx = target[COORD_W-1:0];
  assign ty = target[POS_W-1:COORD_W];
  always_comb begin
    next_head = head;
    if (tx != x) next_head = {tx > x ? ORI_RIGHT : ORI_LEFT, y, tx > x ? x + 4'd1 : x - 4'd1};
    else if (ty != y) next_head = {ty > y ? ORI_DOWN : ORI_UP, ty > y ? y + 4'd1 : y - 4'd1, x};
  end
endmodule

// File: rtl/dragon_head_ctrl.sv
// dragon_head_ctrl: chases the target one cell per move period and tracks dragon length
module dragon_head_ctrl import dragon_pkg::*; #(
  parameter int MOVE_PERIOD = 20,
  parameter int STEP_FRAME = 10,
  parameter int STUN_STEPS = 3,
  parameter logic [POS_W-1:0] START_POS = 8'h00
) (
  input logic clk,
  input logic reset,
  dragon_head_ctrl_if.slave bus
);
  localparam int SW = $clog2(STUN_STEPS + 1);
  localparam logic [SW-1:0] STUN_LOAD = SW'(STUN_STEPS);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_FRAME);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MOVE_PERIOD - 1);
  state_t state_q, state_d;
  logic [HEAD_W-1:0] head_q, head_d, head_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] lu_q, lu_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [SW-1:0] stun_q, stun_d;
  logic step;
  dragon_step_logic u_step (.head(head_q), .target(bus.target_pos), .next_head(head_nxt));
  assign step = bus.vsync && cnt_q == STEP_C;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    stun_d = stun_q;
    cnt_d = bus.vsync ? (cnt_q == LAST_C ? '0 : cnt_q + 6'd1) : cnt_q;
    lu_d = LU_MOVE;
    len_d = len_q;
    if (bus.hit_event) begin
      if (len_q != '0) begin
        len_d = len_q - 3'd1;
        lu_d = LU_HIT;
      end
    end else if (bus.heal_event && len_q != MAX_LEN) begin
      len_d = len_q + 3'd1;
      lu_d = LU_HEAL;
    end
    // a hit takes priority over a coincident step: the stun starts without moving
    case (state_q)
      S_IDLE: if (bus.enable && step) begin
        state_d = S_CHASE;
        head_d = head_nxt;
      end
      S_CHASE: if (!bus.enable) state_d = S_IDLE;
        else if (bus.hit_event) begin
          state_d = S_STUN;
          stun_d = STUN_LOAD;
        end else if (step) head_d = head_nxt;
      S_STUN: if (!bus.enable) begin
          state_d = S_IDLE;
          stun_d = '0;
        end else if (bus.hit_event) stun_d = STUN_LOAD;
        else if (step) begin
          stun_d = stun_q - SW'(1);
          state_d = stun_q == SW'(1) ? S_CHASE : S_STUN;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      head_q <= {ORI_RIGHT, START_POS};
      cnt_q <= '0;
      lu_q <= LU_MOVE;
      len_q <= '0;
      stun_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      cnt_q <= cnt_d;
      lu_q <= lu_d;
      len_q <= len_d;
      stun_q <= stun_d;
    end
  end
  assign bus.dragon_head = head_q;
  assign bus.movement_counter = cnt_q;
  assign bus.length_update = lu_q;
  assign bus.dragon_len = len_q;
  assign bus.stunned = state_q == S_STUN;
endmodule

// File: tb/tb_dragon_head_ctrl.sv
// tb_dragon_head_ctrl: directed + random stimulus checked through a scoreboard against a grid-level model
module tb_dragon_head_ctrl;
  logic clk = 1'b1;
  logic reset;
  always #5 clk = ~clk;
  dragon_head_ctrl_if bus();
  dragon_head_ctrl #(.MOVE_PERIOD(20), .STEP_FRAME(10), .STUN_STEPS(3), .START_POS(8'h00)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  typedef struct {
    logic [9:0] head;
    logic [5:0] cnt;
    logic [1:0] lu;
    logic [2:0] len;
    logic st;
  } snap_t;
  snap_t exp_q[$];
  int tests = 0, fails = 0;
  bit running = 0;
  int m_x, m_y, m_ori, m_mode, m_stun, m_len, m_frame, m_lu;
  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask
  task automatic move_toward(input logic [7:0] tp);
    int dx, dy;
    dx = int'(tp[3:0]) - m_x;
    dy = int'(tp[7:4]) - m_y;
    if (dx != 0) begin
      m_x += dx > 0 ? 1 : -1;
      m_ori = dx > 0 ? 1 : 3;
    end else if (dy != 0) begin
      m_y += dy > 0 ? 1 : -1;
      m_ori = dy > 0 ? 2 : 0;
    end
  endtask
  task automatic model(input logic r, v, e, input logic [7:0] tp, input logic hi, he);
    bit step;
    if (!r) begin
      m_x = 0; m_y = 0; m_ori = 1; m_mode = 0; m_stun = 0; m_len = 0; m_frame = 0; m_lu = 0;
      return;
    end
    step = v && m_frame == 10;
    if (v) m_frame = (m_frame + 1) % 20;
    m_lu = 0;
    if (hi) begin
      if (m_len > 0) begin m_len--; m_lu = 2; end
    end else if (he && m_len < 7) begin
      m_len++; m_lu = 1;
    end
    if (m_mode == 0) begin
      if (e && step) begin m_mode = 1; move_toward(tp); end
    end else if (!e) begin
      m_mode = 0; m_stun = 0;
    end else if (hi) begin
      m_mode = 2; m_stun = 3;
    end else if (step) begin
      if (m_mode == 1) move_toward(tp);
      else begin
        m_stun--;
        if (m_stun == 0) m_mode = 1;
      end
    end
  endtask
  task automatic cyc(input logic r, v, e, input logic [7:0] tp, input logic hi, he);
    snap_t s;
    @(negedge clk);
    reset = r; bus.vsync = v; bus.enable = e; bus.target_pos = tp;
    bus.hit_event = hi; bus.heal_event = he;
    model(r, v, e, tp, hi, he);
    s.head = 10'((m_ori << 8) | (m_y << 4) | m_x);
    s.cnt = 6'(m_frame); s.lu = 2'(m_lu); s.len = 3'(m_len); s.st = m_mode == 2;
    exp_q.push_back(s);
    running = 1;
  endtask
  task automatic run(input int n, input logic r, v, e, input logic [7:0] tp, input logic hi, he);
    for (int i = 0; i < n; i++) cyc(r, v, e, tp, hi, he);
  endtask
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (exp_q.size() == 0) chk("queue_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("dragon_head", int'(bus.dragon_head), int'(e.head));
          chk("movement_counter", int'(bus.movement_counter), int'(e.cnt));
          chk("length_update", int'(bus.length_update), int'(e.lu));
          chk("dragon_len", int'(bus.dragon_len), int'(e.len));
          chk("stunned", int'(bus.stunned), int'(e.st));
        end
      end
    end
  end
  initial begin
    logic en;
    logic [7:0] tp;
    reset = 0; bus.vsync = 0; bus.enable = 0; bus.target_pos = 0;
    bus.hit_event = 0; bus.heal_event = 0;
    run(3, 0, 0, 0, 8'h00, 0, 0);
    run(60, 1, 1, 1, 8'h03, 0, 0);
    run(2, 0, 0, 0, 8'h00, 0, 0);
    run(80, 1, 1, 1, 8'h20, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 8'h20, 0, 1);
      cyc(1, 0, 0, 8'h20, 0, 0);
    end
    run(3, 1, 0, 0, 8'h20, 1, 0);
    run(2, 1, 0, 0, 8'h20, 0, 1);
    run(2, 0, 0, 0, 8'h00, 0, 0);
    run(3, 1, 0, 0, 8'hff, 0, 1);
    run(25, 1, 1, 1, 8'hff, 0, 0);
    cyc(1, 1, 1, 8'hff, 1, 1);
    run(100, 1, 1, 1, 8'hff, 0, 0);
    run(3, 1, 0, 1, 8'hff, 0, 1);
    run(30, 1, 1, 1, 8'hff, 0, 0);
    cyc(1, 0, 1, 8'hff, 1, 0);
    cyc(1, 0, 1, 8'hff, 0, 0);
    run(1, 0, 1, 1, 8'hff, 0, 0);
    run(30, 1, 1, 0, 8'hff, 0, 0);
    run(30, 1, 1, 1, 8'h5a, 0, 0);
    run(70, 1, 1, 0, 8'h5a, 0, 0);
    run(60, 1, 1, 1, 8'h5a, 0, 0);
    run(60, 1, 1, 1, 8'h00, 0, 0);
    en = 1; tp = 8'h77;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) en = !en;
      if ($urandom_range(0, 29) == 0) tp = 8'($urandom);
      cyc($urandom_range(0, 599) != 0, $urandom_range(0, 3) != 0, en, tp,
          $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
